ram_lsu: RTL

Load/store unit between the core's memory stage and the byte-lane data RAM (4 × 8-bit lanes, 4096 words, one-cycle registered read). It decodes the RAM window and drives `ram_en`. It converts byte, half and word requests into per-lane write strobes and word addresses. Accesses that straddle a word boundary are split into two RAM beats. Load data is aligned and sign/zero-extended before it returns to the core.

---
 rtl/ram_lsu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_lsu.sv
// Load/store unit between the core memory stage and a 4-lane byte-addressable data RAM.
// Splits word-straddling accesses into two beats and aligns/extends load data.
module ram_lsu #(
  parameter logic [31:0] RAM_BASE = 32'h1000_0000,
  parameter int unsigned RAM_AW   = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        ram_en,
  output logic [3:0]  wen,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        ren,
  output logic [31:0] r_addr_o,
  input  logic [31:0] r_data_i
);

  typedef enum logic [2:0] {IDLE, B0, B1, WAIT, RSP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        split_q;
  logic [3:0]  wen_hi_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] buf_lo;

  function automatic logic in_window(input logic [31:0] a);
    return a[31:RAM_AW] == RAM_BASE[31:RAM_AW];
  endfunction

  logic [3:0]  mask_b;
  logic [31:0] wdata_sz;
  logic [1:0]  span;
  logic [7:0]  mask0;
  logic [63:0] data0;
  logic [31:0] last_addr;
  logic [31:0] base0;
  logic        req_err;

  // Lane mask and steered data for the request being presented at accept.
  always_comb begin
    mask_b   = 4'b1111;
    wdata_sz = req_wdata;
    span     = 2'd3;
    case (req_size)
      2'd0: begin mask_b = 4'b0001; wdata_sz = {24'b0, req_wdata[7:0]};  span = 2'd0; end
      2'd1: begin mask_b = 4'b0011; wdata_sz = {16'b0, req_wdata[15:0]}; span = 2'd1; end
      default: ;
    endcase
    mask0     = {4'b0000, mask_b} << req_addr[1:0];
    data0     = {32'b0, wdata_sz} << {req_addr[1:0], 3'b000};
    last_addr = req_addr + {30'b0, span};
    base0     = {req_addr[31:2], 2'b00};
    req_err   = (req_size == 2'd3) || !in_window(req_addr) || !in_window(last_addr);
  end

  logic [31:0] beat1_addr;
  logic [63:0] full;
  logic [31:0] aligned;
  logic [31:0] merged;

  always_comb begin
    beat1_addr = {addr_q[31:2], 2'b00} + 32'd4;
    full       = split_q ? {r_data_i, buf_lo} : {32'b0, r_data_i};
    aligned    = 32'(full >> {addr_q[1:0], 3'b000});
    merged     = aligned;
    case (size_q)
      2'd0: merged = uns_q ? {24'b0, aligned[7:0]}  : {{24{aligned[7]}}, aligned[7:0]};
      2'd1: merged = uns_q ? {16'b0, aligned[15:0]} : {{16{aligned[15]}}, aligned[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      ram_en     <= 1'b0;
      wen        <= '0;
      w_addr_o   <= '0;
      w_data_o   <= '0;
      ren        <= 1'b0;
      r_addr_o   <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      wen_hi_q   <= '0;
      wdata_hi_q <= '0;
      buf_lo     <= '0;
    end else begin
      // RAM port and response outputs are single-cycle unless re-asserted below.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_en    <= 1'b0;
      wen       <= '0;
      w_addr_o  <= '0;
      w_data_o  <= '0;
      ren       <= 1'b0;
      r_addr_o  <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            addr_q     <= req_addr;
            size_q     <= req_size;
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            split_q    <= |mask0[7:4];
            wen_hi_q   <= mask0[7:4];
            wdata_hi_q <= data0[63:32];
            if (req_err) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state    <= B0;
              ram_en   <= 1'b1;
              w_addr_o <= base0;
              r_addr_o <= base0;
              if (req_we) begin
                wen      <= mask0[3:0];
                w_data_o <= data0[31:0];
              end else begin
                ren <= 1'b1;
              end
            end
          end
        end
        B0: begin
          if (split_q) begin
            state    <= B1;
            ram_en   <= 1'b1;
            w_addr_o <= beat1_addr;
            r_addr_o <= beat1_addr;
            if (we_q) begin
              wen      <= wen_hi_q;
              w_data_o <= wdata_hi_q;
            end else begin
              ren <= 1'b1;
            end
          end else if (we_q) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        B1: begin
          if (we_q) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else begin
            buf_lo <= r_data_i;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // Last beat's data arrives now; merge straight from the port into the response.
          rsp_rdata <= merged;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
